host_serial_bridge: RTL and testbench

- Host-side initiator for the main_core_serialCmd port set.
- Parses a byte stream (UART/debug link) into core commands and 64-bit input words.
- Drains 64-bit core output words back out as bytes.
- Sits between the host link and the core, playing the role the bench plays today.

---
 rtl/host_serial_bridge_pkg.sv | 28 ++
 rtl/host_serial_bridge_shift.sv | 31 +++
 rtl/host_serial_bridge.sv | 163 ++++++++++++++++
 tb/tb_host_serial_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_serial_bridge_pkg.sv
// Shared definitions for host_serial_bridge: header opcodes, FSM encodings, byte swap.
// Build option HOSTBRIDGE_BIG_ENDIAN_EN selects MSB-first word byte order (see top).
package host_serial_bridge_pkg;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD_COL = 3'd1;
    localparam logic [2:0] ST_CMD_ISS = 3'd2;
    localparam logic [2:0] ST_LEN     = 3'd3;
    localparam logic [2:0] ST_WR_COL  = 3'd4;
    localparam logic [2:0] ST_WR_ISS  = 3'd5;
    localparam logic [2:0] ST_RD_WAIT = 3'd6;
    localparam logic [2:0] ST_RD_EMIT = 3'd7;

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/host_serial_bridge_shift.sv
// 64-bit byte shift register: parallel load, byte shift-in at the top, byte shift-out at the bottom.
// Shared by the WRITE collect path and the READ serialise path of host_serial_bridge.
module host_serial_bridge_shift
    import host_serial_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        shift_in,
    input  logic [7:0]  byte_in,
    input  logic        shift_out,
    output logic [63:0] data,
    output logic [7:0]  byte_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_in) begin
            data <= {byte_in, data[63:8]};
        end else if (shift_out) begin
            data <= {8'h00, data[63:8]};
        end
    end

    assign byte_out = data[7:0];

endmodule

// File: rtl/host_serial_bridge.sv
// Host byte-stream to core command/word bridge (CMD, WRITE, READ, NOP frames).
// Define HOSTBRIDGE_BIG_ENDIAN_EN for MSB-first word bytes; default build is LSB first.
module host_serial_bridge
    import host_serial_bridge_pkg::*;
#(
    parameter int CMD_W     = 16,
    parameter int CMD_BYTES = (CMD_W + 7) / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       hin,
    input  logic             hin_isReady,
    output logic             hin_canReceive,
    output logic [7:0]       hout,
    output logic             hout_isReady,
    input  logic             hout_canReceive,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_hasAny,
    input  logic             cmd_consume,
    output logic [63:0]      in,
    output logic             in_isReady,
    input  logic             in_canReceive,
    input  logic [63:0]      out,
    input  logic             out_isReady,
    output logic             out_canReceive
);

    localparam int CB_W = CMD_BYTES * 8;

    logic [2:0]      state;
    logic [2:0]      byte_idx;
    logic [7:0]      word_cnt;
    logic [7:0]      len;
    logic            is_read;
    logic [CB_W-1:0] cmd_buf;
    logic [CB_W+7:0] cmd_cat;

    logic            hin_fire;
    logic            sh_load;
    logic            sh_in;
    logic            sh_out;
    logic [63:0]     sh_data;
    logic [63:0]     sh_load_data;
    logic [7:0]      sh_byte;

    // Gated by rst so the host sees no acceptance while reset is held.
    assign hin_canReceive = rst && ((state == ST_IDLE) || (state == ST_CMD_COL) ||
                                    (state == ST_LEN)  || (state == ST_WR_COL));
    assign cmd_hasAny     = (state == ST_CMD_ISS);
    assign in_isReady     = (state == ST_WR_ISS);
    assign out_canReceive = (state == ST_RD_WAIT);
    assign hout_isReady   = (state == ST_RD_EMIT);

    assign hin_fire = hin_isReady && hin_canReceive;
    assign sh_load  = out_isReady && out_canReceive;
    assign sh_in    = hin_fire && (state == ST_WR_COL);
    assign sh_out   = hout_isReady && hout_canReceive;

`ifdef HOSTBRIDGE_BIG_ENDIAN_EN
    assign sh_load_data = bswap64(out);
    assign in           = bswap64(sh_data);
`else
    assign sh_load_data = out;
    assign in           = sh_data;
`endif

    assign hout    = sh_byte;
    assign cmd     = cmd_buf[CMD_W-1:0];
    assign cmd_cat = {hin, cmd_buf};

    host_serial_bridge_shift u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift_in  (sh_in),
        .byte_in   (hin),
        .shift_out (sh_out),
        .data      (sh_data),
        .byte_out  (sh_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
            word_cnt <= '0;
            len      <= '0;
            is_read  <= 1'b0;
            cmd_buf  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hin_fire) begin
                        byte_idx <= '0;
                        case (hin[7:6])
                            OP_CMD:   state <= ST_CMD_COL;
                            OP_WRITE: begin is_read <= 1'b0; state <= ST_LEN; end
                            OP_READ:  begin is_read <= 1'b1; state <= ST_LEN; end
                            default:  state <= ST_IDLE;
                        endcase
                    end
                end
                ST_CMD_COL: begin
                    if (hin_fire) begin
                        cmd_buf <= cmd_cat[CB_W+7:8];
                        if (byte_idx == 3'(CMD_BYTES - 1)) begin
                            byte_idx <= '0;
                            state    <= ST_CMD_ISS;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                ST_CMD_ISS: begin
                    if (cmd_consume) state <= ST_IDLE;
                end
                ST_LEN: begin
                    if (hin_fire) begin
                        len      <= hin;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        state    <= is_read ? ST_RD_WAIT : ST_WR_COL;
                    end
                end
                ST_WR_COL: begin
                    if (hin_fire) begin
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == 3'd7) state <= ST_WR_ISS;
                    end
                end
                ST_WR_ISS: begin
                    if (in_canReceive) begin
                        if (word_cnt == len) begin
                            state <= ST_IDLE;
                        end else begin
                            word_cnt <= word_cnt + 8'd1;
                            state    <= ST_WR_COL;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (out_isReady) state <= ST_RD_EMIT;
                end
                ST_RD_EMIT: begin
                    if (hout_canReceive) begin
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == 3'd7) begin
                            if (word_cnt == len) begin
                                state <= ST_IDLE;
                            end else begin
                                word_cnt <= word_cnt + 8'd1;
                                state    <= ST_RD_WAIT;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_serial_bridge.sv
// Self-checking bench for host_serial_bridge: directed frames plus random frames against a frame-level model.
module tb_host_serial_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  hin = '0;
    logic        hin_isReady = 1'b0;
    logic        hin_canReceive;
    logic [7:0]  hout;
    logic        hout_isReady;
    logic        hout_canReceive = 1'b0;
    logic [15:0] cmd;
    logic        cmd_hasAny;
    logic        cmd_consume = 1'b0;
    logic [63:0] in_w;
    logic        in_isReady;
    logic        in_canReceive = 1'b0;
    logic [63:0] out = '0;
    logic        out_isReady = 1'b0;
    logic        out_canReceive;

    host_serial_bridge #(.CMD_W(16), .CMD_BYTES(2)) dut (
        .clk(clk), .rst(rst),
        .hin(hin), .hin_isReady(hin_isReady), .hin_canReceive(hin_canReceive),
        .hout(hout), .hout_isReady(hout_isReady), .hout_canReceive(hout_canReceive),
        .cmd(cmd), .cmd_hasAny(cmd_hasAny), .cmd_consume(cmd_consume),
        .in(in_w), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
        .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cap_cyc = -10;
    int cons_mode = 1;

    logic [15:0] cmd_q[$];
    logic [63:0] in_q[$];
    logic [63:0] core_q[$];
    logic [7:0]  hout_q[$];

    logic        cmd_hold = 1'b0, in_hold = 1'b0, hout_hold = 1'b0;
    logic [15:0] cmd_prev;
    logic [63:0] in_prev;
    logic [7:0]  hout_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Frame-level model: eight consecutive stream bytes to one core word.
    function automatic logic [63:0] model_word(input logic [7:0] b[$], input int base);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef HOSTBRIDGE_BIG_ENDIAN_EN
            w = (w << 8) | 64'(b[base+i]);
`else
            w = w | (64'(b[base+i]) << (8*i));
`endif
        end
        return w;
    endfunction

    function automatic logic [7:0] model_byte(input logic [63:0] w, input int i);
`ifdef HOSTBRIDGE_BIG_ENDIAN_EN
        return 8'(w >> (8*(7-i)));
`else
        return 8'(w >> (8*i));
`endif
    endfunction

    // Core command sink
    initial begin
        forever begin
            @(negedge clk);
            cmd_consume = (cons_mode == 2) ? 1'b1 :
                          (cons_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
            #1;
            if (cmd_hasAny && cmd_hold) check("cmd_stable", cmd, cmd_prev);
            if (cmd_hasAny && cmd_consume) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", cmd_q.size(), 1);
                else check("cmd", cmd, cmd_q.pop_front());
                cmd_hold = 1'b0;
            end else begin
                cmd_hold = cmd_hasAny;
                cmd_prev = cmd;
            end
            if (cmd_hasAny || in_isReady || hout_isReady || out_canReceive)
                check("no_concurrency", hin_canReceive, 0);
        end
    end

    // Core word sink
    initial begin
        forever begin
            @(negedge clk);
            in_canReceive = ($urandom_range(0, 2) != 0);
            #1;
            if (in_isReady && in_hold) check("in_stable", in_w, in_prev);
            if (in_isReady && in_canReceive) begin
                if (in_q.size() == 0) check("in_unexpected", in_q.size(), 1);
                else check("in_word", in_w, in_q.pop_front());
                in_hold = 1'b0;
            end else begin
                in_hold = in_isReady;
                in_prev = in_w;
            end
        end
    end

    // Core word source
    initial begin
        forever begin
            @(negedge clk);
            out_isReady = (core_q.size() > 0) && ($urandom_range(0, 2) != 0);
            out = (core_q.size() > 0) ? core_q[0] : {$urandom(), $urandom()};
            #1;
            if (out_isReady && out_canReceive) begin
                void'(core_q.pop_front());
                cap_cyc = cyc;
            end
        end
    end

    // Host byte sink
    initial begin
        forever begin
            @(negedge clk);
            hout_canReceive = ($urandom_range(0, 3) != 0);
            #1;
            if (cap_cyc == cyc - 1) check("rd_latency", hout_isReady, 1);
            if (hout_isReady && hout_hold) check("hout_stable", hout, hout_prev);
            if (hout_isReady && hout_canReceive) begin
                if (hout_q.size() == 0) check("hout_unexpected", hout_q.size(), 1);
                else check("hout_byte", hout, hout_q.pop_front());
                hout_hold = 1'b0;
            end else begin
                hout_hold = hout_isReady;
                hout_prev = hout;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        hin = b;
        hin_isReady = 1'b1;
        while (!hin_canReceive && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("hin_accept_timeout", hin_canReceive, 1);
        @(posedge clk);
        #1;
        hin_isReady = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((cmd_q.size() + in_q.size() + core_q.size() + hout_q.size()) != 0 && t < 20000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("drain", cmd_q.size() + in_q.size() + core_q.size() + hout_q.size(), 0);
        @(negedge clk);
        #2;
        check("idle_accepts", hin_canReceive, 1);
    endtask

    task automatic cmd_frame(input logic [7:0] hdr, input logic [15:0] c);
        cmd_q.push_back(c);
        send_byte(hdr);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
    endtask

    task automatic write_frame(input logic [7:0] hdr, input logic [7:0] l, input logic [7:0] data[$]);
        for (int w = 0; w <= int'(l); w++) in_q.push_back(model_word(data, 8*w));
        send_byte(hdr);
        send_byte(l);
        for (int i = 0; i < data.size(); i++) begin
            send_byte(data[i]);
            if (i % 8 == 7) check("wr_latency", in_isReady, 1);
        end
    endtask

    task automatic read_frame(input logic [7:0] hdr, input logic [7:0] l, input logic [63:0] words[$]);
        for (int w = 0; w <= int'(l); w++) begin
            core_q.push_back(words[w]);
            for (int i = 0; i < 8; i++) hout_q.push_back(model_byte(words[w], i));
        end
        send_byte(hdr);
        send_byte(l);
    endtask

    initial begin
        logic [7:0]  bytes[$];
        logic [63:0] words[$];
        logic [7:0]  l;
        int          op;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_hasAny", cmd_hasAny, 0);
        check("rst_in_isReady", in_isReady, 0);
        check("rst_hout_isReady", hout_isReady, 0);
        check("rst_out_canReceive", out_canReceive, 0);
        check("rst_cmd", cmd, 0);
        check("rst_in", in_w, 0);
        check("rst_hout", hout, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release_hin_canReceive", hin_canReceive, 1);

        // CMD held by a stalled core
        cons_mode = 0;
        cmd_frame(8'h00, 16'h1234);
        check("cmd_latency", cmd_hasAny, 1);
        check("cmd_value", cmd, 16'h1234);
        repeat (5) begin
            @(negedge clk);
            #2;
            check("cmd_hold_value", cmd, 16'h1234);
            check("cmd_hold_hin_blocked", hin_canReceive, 0);
        end
        cons_mode = 2;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("cmd_consumed", cmd_hasAny, 0);
        cons_mode = 1;
        drain();

        // NOP then reserved bits in a CMD header
        send_byte(8'hFF);
        cmd_frame(8'h3F, 16'h1234);
        drain();

        // WRITE, two words
        bytes = {};
        for (int i = 1; i <= 8; i++) bytes.push_back(8'(i));
        for (int i = 1; i <= 8; i++) bytes.push_back(8'(8'h10 + i));
        write_frame(8'h40, 8'd1, bytes);
        drain();

        // READ, one word
        words = {64'hDEADBEEF01234567};
        read_frame(8'h80, 8'd0, words);
        drain();

        // Reset in the middle of a WRITE frame
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_hin_canReceive", hin_canReceive, 0);
        check("midrst_cmd_hasAny", cmd_hasAny, 0);
        check("midrst_in_isReady", in_isReady, 0);
        check("midrst_hout_isReady", hout_isReady, 0);
        check("midrst_out_canReceive", out_canReceive, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_release", hin_canReceive, 1);
        cmd_frame(8'h00, 16'hABCD);
        drain();

        // Random frames
        for (int f = 0; f < 40; f++) begin
            op = $urandom_range(0, 3);
            l  = 8'($urandom_range(0, 3));
            case (op)
                0: cmd_frame({2'b00, 6'($urandom)}, 16'($urandom));
                1: begin
                    bytes = {};
                    for (int i = 0; i < (int'(l) + 1) * 8; i++) bytes.push_back(8'($urandom));
                    write_frame({2'b01, 6'($urandom)}, l, bytes);
                end
                2: begin
                    words = {};
                    for (int i = 0; i <= int'(l); i++) words.push_back({$urandom(), $urandom()});
                    read_frame({2'b10, 6'($urandom)}, l, words);
                end
                default: send_byte({2'b11, 6'($urandom)});
            endcase
            drain();
        end

        // Maximum length: L=255 moves 256 words
        bytes = {};
        for (int i = 0; i < 256 * 8; i++) bytes.push_back(8'($urandom));
        write_frame(8'h40, 8'd255, bytes);
        drain();
        words = {};
        for (int i = 0; i < 256; i++) words.push_back({$urandom(), $urandom()});
        read_frame(8'h80, 8'd255, words);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
